fpu_result_queue: RTL and testbench
===================================

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; power of two, 2..16.
REQ-002 Parameter: CNT_W, 16, width of statistics counters.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-005 Port: in_val  input  1  upstream result valid; connects to fpu_top result_val.
REQ-006 Port: in_bits  input  32  upstream IEEE-754 single result; connects to fpu_top result_bits.
REQ-007 Port: in_rdy  output  1  queue can accept; connects to fpu_top result_rdy.
REQ-008 Port: out_val  output  1  head entry valid.
REQ-009 Port: out_bits  output  32  head entry result word.
REQ-010 Port: out_class  output  3  head entry class code (REQ-020).
REQ-011 Port: out_rdy  input  1  downstream consumer ready.
REQ-012 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 Port: clr_stats  input  1  synchronous clear of statistics counters.
REQ-014 Port: total_cnt  output  CNT_W  saturating count of accepted results.
REQ-015 Port: nan_cnt  output  CNT_W  saturating count of accepted NaN results.

Function
REQ-016 Push occurs on a rising edge with in_val=1 and in_rdy=1; pop occurs on a rising edge with out_val=1 and out_rdy=1.
REQ-017 in_rdy SHALL be 1 exactly when count<DEPTH and reset is deasserted; in_rdy SHALL NOT depend combinationally on out_rdy or in_val.
REQ-018 out_val SHALL be 1 exactly when count!=0; out_bits/out_class SHALL show the oldest entry, stable while out_val=1 and out_rdy=0.
REQ-019 Latency: a pushed entry SHALL appear on out_* at the earliest one cycle after the push edge; no same-cycle bypass.
REQ-020 Class codes, computed from in_bits at push and stored with the entry: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 quiet NaN (exp=FF, frac[22]=1), 5 signalling NaN (exp=FF, frac[22]=0, frac!=0); 6-7 unused.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Full (count=DEPTH): in_rdy=0; a pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-023 Empty (count=0): a push SHALL occur; no pop SHALL occur even if out_rdy=1.
REQ-024 Read/write pointers SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-025 Order SHALL be strictly FIFO; no entry dropped or duplicated.
REQ-026 total_cnt SHALL increment on every push, saturating at all-ones; nan_cnt SHALL increment on pushes of class 4 or 5, saturating at all-ones.
REQ-027 clr_stats=1 SHALL zero both counters on that edge, overriding any same-cycle increment; queue contents SHALL be unaffected.

Reset
REQ-028 On reset: count=0, pointers=0, out_val=0, in_rdy=0, total_cnt=0, nan_cnt=0; out_bits=0 and out_class=0.
REQ-029 A reset during operation SHALL discard all stored entries; in_rdy SHALL return to 1 on the first edge after reset deassertion.
REQ-030 Entry storage array need not be reset.

Structure
REQ-031 Package fpu_pkg SHALL hold the class-code enum, F32 field-width constants (EXP_W=8, FRAC_W=23), and F32_QNAN=32'h7FC00000.
REQ-032 Classification SHALL be a combinational sub-module fpu_classify (32-bit in, 3-bit class out), instantiated once on the push path.
REQ-033 Storage SHALL be a register array of DEPTH x 35 bits (32 result bits plus 3 class bits).

Verification
REQ-034 Push 0x40000000 with out_rdy=1 -> out_val=1 the next cycle, out_bits=0x40000000, out_class=2, total_cnt=1.
REQ-035 With out_rdy=0, push 0x3F800000, 0x00000000, 0x7F800000, 0x00000001 -> in_rdy=0 and count=4; a fifth in_val is held off; drain order and classes are 2, 0, 3, 1.
REQ-036 Push 0x7FC00000 then 0x7F800001 -> classes 4 then 5, nan_cnt=2; pulse clr_stats -> both counters 0 while contents remain.
REQ-037 Continuous push/pop at full rate over 10 entries -> count constant, pointers wrap, outputs in FIFO order.
REQ-038 Reset asserted with count=3 -> next cycle count=0, out_val=0; after deassertion in_rdy=1.
REQ-039 fpu_top to queue: 1.0+1.0 -> out_bits=0x40000000, class 2.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, result class codes
// and the queue entry layout.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    FC_ZERO = 3'd0,
    FC_SUB  = 3'd1,
    FC_NORM = 3'd2,
    FC_INF  = 3'd3,
    FC_QNAN = 3'd4,
    FC_SNAN = 3'd5
  } fp_class_e;

  // 35-bit stored entry: result word plus its class
  typedef struct packed {
    logic [31:0] bits;
    fp_class_e   cls;
  } entry_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational IEEE-754 single classifier; sign does not affect the class.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0] bits,
  output fp_class_e   cls
);

  logic [31:0]       mag;
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign mag    = bits & 32'h7FFF_FFFF;
  assign exp_f  = mag[30:23];
  assign frac_f = mag[22:0];

  always_comb begin
    cls = FC_NORM;
    if (mag == '0)
      cls = FC_ZERO;
    else if (exp_f == '0)
      cls = FC_SUB;
    else if (exp_f == '1) begin
      if (frac_f == '0)               cls = FC_INF;
      else if (frac_f[FRAC_W-1])      cls = FC_QNAN;
      else                            cls = FC_SNAN;
    end
  end

endmodule

// File: rtl/fpu_result_queue.sv
// Result FIFO between the FPU and its consumer; tags each result with its
// class on entry and keeps saturating totals of accepted and NaN results.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  input  logic [31:0]              in_bits,
  output logic                     in_rdy,
  output logic                     out_val,
  output logic [31:0]              out_bits,
  output logic [2:0]               out_class,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         nan_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  entry_t [DEPTH-1:0] mem;
  entry_t             head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               rst_done, push, pop, is_nan;
  fp_class_e          in_class;

  fpu_classify u_classify (.bits(in_bits), .cls(in_class));

  // rst_done holds in_rdy low until the first edge after reset is released
  assign in_rdy  = rst_done & reset & (count < FULL);
  assign out_val = (count != '0);
  assign push    = in_val & in_rdy;
  assign pop     = out_val & out_rdy;
  assign is_nan  = (in_class == FC_QNAN) || (in_class == FC_SNAN);

  assign head      = mem[rd_ptr];
  assign out_bits  = out_val ? head.bits : '0;
  assign out_class = out_val ? head.cls  : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_done <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{bits: in_bits, cls: in_class};
  end

  // clear wins over a same-edge increment
  always_ff @(posedge clk) begin
    if (!reset || clr_stats) begin
      total_cnt <= '0;
      nan_cnt   <= '0;
    end else if (push) begin
      if (total_cnt != '1)          total_cnt <= total_cnt + 1'b1;
      if (is_nan && nan_cnt != '1)  nan_cnt   <= nan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: classification table plus hand-written
// corner sequences, with a scoreboard checking every popped entry.
module tb_fpu_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk, reset, in_val, in_rdy, out_val, out_rdy, clr_stats;
  logic [31:0]       in_bits, out_bits;
  logic [2:0]        out_class;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]  total_cnt, nan_cnt;

  fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_bits(in_bits), .in_rdy(in_rdy),
    .out_val(out_val), .out_bits(out_bits), .out_class(out_class), .out_rdy(out_rdy),
    .count(count), .clr_stats(clr_stats), .total_cnt(total_cnt), .nan_cnt(nan_cnt)
  );

  typedef struct packed {
    logic [2:0]  cls;
    logic [31:0] bits;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    logic [2:0]  cls;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every pop the DUT is about to perform must match the oldest push.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_val === 1'b1 && out_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got %h want none", out_bits);
      end else begin
        mon_e = sb.pop_front();
        chk("out_bits", out_bits, mon_e.bits);
        chk("out_class", {29'd0, out_class}, {29'd0, mon_e.cls});
      end
    end
  end

  task automatic push(input logic [31:0] b, input logic [2:0] c);
    int n;
    n = 0;
    in_val = 1'b1;
    in_bits = b;
    forever begin
      @(negedge clk);
      if (in_rdy) begin
        sb.push_back({c, b});
        break;
      end
      n++;
      if (n > 50) begin
        chk("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_rdy = 1'b1;
    while (count != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_count", {28'd0, count}, 32'd0);
    chk("drain_sb", sb.size(), 32'd0);
    out_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nans;
    reset = 1'b0; in_val = 1'b0; in_bits = '0; out_rdy = 1'b0; clr_stats = 1'b0;

    tbl[0]  = '{32'h4000_0000, 3'd2};
    tbl[1]  = '{32'h3F80_0000, 3'd2};
    tbl[2]  = '{32'h0000_0000, 3'd0};
    tbl[3]  = '{32'h8000_0000, 3'd0};
    tbl[4]  = '{32'h0000_0001, 3'd1};
    tbl[5]  = '{32'h807F_FFFF, 3'd1};
    tbl[6]  = '{32'h7F80_0000, 3'd3};
    tbl[7]  = '{32'hFF80_0000, 3'd3};
    tbl[8]  = '{32'h7FC0_0000, 3'd4};
    tbl[9]  = '{32'hFFFF_FFFF, 3'd4};
    tbl[10] = '{32'h7F80_0001, 3'd5};
    tbl[11] = '{32'h7FBF_FFFF, 3'd5};
    tbl[12] = '{32'h7F7F_FFFF, 3'd2};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("rst_total", {28'd0, total_cnt}, 32'd0);
    chk("rst_nan", {28'd0, nan_cnt}, 32'd0);
    chk("rst_out_bits", out_bits, 32'd0);
    chk("rst_out_class", {29'd0, out_class}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_in_rdy", {31'd0, in_rdy}, 32'd1);

    // single push, one-cycle latency, no bypass
    @(posedge clk); #1;
    out_rdy = 1'b1; in_val = 1'b1; in_bits = 32'h4000_0000;
    @(negedge clk);
    chk("nobypass_out_val", {31'd0, out_val}, 32'd0);
    chk("first_in_rdy", {31'd0, in_rdy}, 32'd1);
    sb.push_back({3'd2, 32'h4000_0000});
    @(posedge clk); #1;
    in_val = 1'b0;
    @(negedge clk);
    chk("lat_out_val", {31'd0, out_val}, 32'd1);
    chk("lat_total", {28'd0, total_cnt}, 32'd1);
    @(posedge clk); #1;

    // classification table at full rate
    nans = 0;
    for (int i = 0; i < 13; i++) begin
      push(tbl[i].bits, tbl[i].cls);
      if (tbl[i].cls == 3'd4 || tbl[i].cls == 3'd5) nans++;
    end
    drain();
    chk("tbl_total", {28'd0, total_cnt}, 32'(1 + 13));
    chk("tbl_nan", {28'd0, nan_cnt}, 32'(nans));

    // NaN counting and clear overriding a same-edge push
    pulse_clr();
    @(negedge clk);
    chk("clr_total", {28'd0, total_cnt}, 32'd0);
    chk("clr_nan", {28'd0, nan_cnt}, 32'd0);
    @(posedge clk); #1;
    push(32'h7FC0_0000, 3'd4);
    push(32'h7F80_0001, 3'd5);
    @(negedge clk);
    chk("nan2_nan", {28'd0, nan_cnt}, 32'd2);
    chk("nan2_total", {28'd0, total_cnt}, 32'd2);
    chk("nan2_count", {28'd0, count}, 32'd2);
    @(posedge clk); #1;
    in_val = 1'b1; in_bits = 32'h3F80_0000; clr_stats = 1'b1;
    @(negedge clk);
    chk("clrpush_in_rdy", {31'd0, in_rdy}, 32'd1);
    sb.push_back({3'd2, 32'h3F80_0000});
    @(posedge clk); #1;
    in_val = 1'b0; clr_stats = 1'b0;
    @(negedge clk);
    chk("clrpush_total", {28'd0, total_cnt}, 32'd0);
    chk("clrpush_nan", {28'd0, nan_cnt}, 32'd0);
    chk("clrpush_count", {28'd0, count}, 32'd3);
    @(posedge clk); #1;
    drain();

    // fill to full, hold off a fifth, pop on full does not admit a push
    push(32'h3F80_0000, 3'd2);
    push(32'h0000_0000, 3'd0);
    push(32'h7F80_0000, 3'd3);
    push(32'h0000_0001, 3'd1);
    @(negedge clk);
    chk("full_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("full_count", {28'd0, count}, 32'd4);
    @(posedge clk); #1;
    in_val = 1'b1; in_bits = 32'h4049_0FDB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("hold_count", {28'd0, count}, 32'd4);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("fullpop_in_rdy", {31'd0, in_rdy}, 32'd0);
    @(posedge clk); #1;
    out_rdy = 1'b0;
    @(negedge clk);
    chk("afterpop_count", {28'd0, count}, 32'd3);
    chk("afterpop_in_rdy", {31'd0, in_rdy}, 32'd1);
    sb.push_back({3'd2, 32'h4049_0FDB});
    @(posedge clk); #1;
    in_val = 1'b0;
    @(negedge clk);
    chk("refill_count", {28'd0, count}, 32'd4);
    @(posedge clk); #1;
    drain();

    // sustained simultaneous push/pop across pointer wrap
    push(32'h4100_0000, 3'd2);
    push(32'h4100_0001, 3'd2);
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_val = 1'b1; in_bits = 32'h4100_0002 + 32'(i);
      @(negedge clk);
      chk("stream_count", {28'd0, count}, 32'd2);
      chk("stream_in_rdy", {31'd0, in_rdy}, 32'd1);
      sb.push_back({3'd2, in_bits});
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    drain();

    // counter saturation
    pulse_clr();
    out_rdy = 1'b1;
    for (int i = 0; i < SAT + 5; i++) push(32'h7FC0_0000, 3'd4);
    drain();
    chk("sat_total", {28'd0, total_cnt}, 32'(SAT));
    chk("sat_nan", {28'd0, nan_cnt}, 32'(SAT));

    // reset mid-operation discards contents
    push(32'h3F80_0000, 3'd2);
    push(32'h4000_0000, 3'd2);
    push(32'h4040_0000, 3'd2);
    @(negedge clk);
    chk("pre_rst_count", {28'd0, count}, 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_out_val", {31'd0, out_val}, 32'd0);
    chk("midrst_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("midrst_total", {28'd0, total_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("prerel_in_rdy", {31'd0, in_rdy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrel_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("postrel_out_val", {31'd0, out_val}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
